// File: rtl/spw_pkg.sv
// Shared SpaceWire receive-side types: 9-bit character, end markers and packet state.
package spw_pkg;

  typedef logic [8:0] spw_char_t;

  localparam spw_char_t EOP_CHAR = 9'h100;
  localparam spw_char_t EEP_CHAR = 9'h101;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECV    = 2'd1,
    DISCARD = 2'd2
  } rx_pkt_state_t;

  function automatic logic isEndMarker(input spw_char_t c);
    return c[8];
  endfunction

endpackage

// File: rtl/spw_rx_fifo_if.sv
// Codec-write / RMAP-read bus of the receive FIFO. pktState is a debug view of the
// packet state machine (held at IDLE when store-and-forward is not built in).
interface spw_rx_fifo_if
  import spw_pkg::*;
#(
    parameter int DEPTH_LOG2 = 5
);
    // Strobes are single-cycle requests: writeEnable is taken when full is low and
    // readEnable when empty is low, both judged on the values before the edge.
    logic                  writeEnable;
    spw_char_t             dataIn;
    logic                  full;
    logic                  readEnable;
    spw_char_t             dataOut;
    logic                  empty;
    logic [DEPTH_LOG2:0]   level;
    logic                  overflow;
    logic                  underflow;
    logic                  clearStatus;
    rx_pkt_state_t         pktState;

    modport slave (
        input  writeEnable, dataIn, readEnable, clearStatus,
        output full, dataOut, empty, level, overflow, underflow, pktState
    );

    modport master (
        output writeEnable, dataIn, readEnable, clearStatus,
        input  full, dataOut, empty, level, overflow, underflow, pktState
    );

endinterface

// File: rtl/spw_fifo_ram.sv
// Storage for spw_rx_fifo: one write port and one registered read port.
module spw_fifo_ram
  import spw_pkg::*;
#(
    parameter int DEPTH_LOG2 = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_waddr,
    input  spw_char_t             i_wdata,
    input  logic                  i_re,
    input  logic [DEPTH_LOG2-1:0] i_raddr,
    output spw_char_t             o_rdata
);

    spw_char_t r_mem [2**DEPTH_LOG2];
    spw_char_t r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/spw_rx_fifo.sv
// SpaceWire receive FIFO between codec and RMAP target.
// Define SPW_RX_STORE_AND_FORWARD_EN to expose only complete EOP-terminated packets.
module spw_rx_fifo
  import spw_pkg::*;
#(
    parameter int DEPTH_LOG2 = 5
) (
    input  logic           clk,
    input  logic           rst,
    spw_rx_fifo_if.slave   bus
);

    localparam int PW = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [PW-1:0] r_wr_ptr, r_rd_ptr, r_level;
    logic          r_full, r_empty, r_overflow, r_underflow;
    logic [PW-1:0] w_wr_ptr_nxt, w_rd_ptr_nxt, w_base_nxt, w_level_nxt;
    logic          w_full_nxt, w_full_out, w_rd_acc, w_mem_we, w_ovf_set, w_udf_set;

    assign w_rd_acc     = bus.readEnable && !r_empty;
    assign w_rd_ptr_nxt = r_rd_ptr + PW'(w_rd_acc);
    assign w_udf_set    = bus.readEnable && r_empty;

`ifdef SPW_RX_STORE_AND_FORWARD_EN
    rx_pkt_state_t r_state, w_state_nxt;
    logic [PW-1:0] r_commit_ptr, w_commit_nxt;
    logic          w_is_end, w_no_commit;

    assign w_is_end    = isEndMarker(bus.dataIn);
    assign w_no_commit = (r_commit_ptr == r_rd_ptr);
    assign w_full_out  = r_full && (r_state != DISCARD);

    always_comb begin
        w_state_nxt  = r_state;
        w_wr_ptr_nxt = r_wr_ptr;
        w_commit_nxt = r_commit_ptr;
        w_mem_we     = 1'b0;
        w_ovf_set    = bus.writeEnable && w_full_out;
        case (r_state)
            IDLE: begin
                // A lone end marker carries no data and is dropped here.
                if (bus.writeEnable && !r_full && !w_is_end) begin
                    w_mem_we     = 1'b1;
                    w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
                    w_state_nxt  = RECV;
                end
            end
            RECV: begin
                // The open packet fills the whole buffer: it can never be committed.
                if (r_full && w_no_commit) begin
                    w_wr_ptr_nxt = r_commit_ptr;
                    w_ovf_set    = 1'b1;
                    w_state_nxt  = (bus.writeEnable && w_is_end) ? IDLE : DISCARD;
                end else if (bus.writeEnable && !r_full) begin
                    if (w_is_end && bus.dataIn[0]) begin
                        w_wr_ptr_nxt = r_commit_ptr;
                        w_state_nxt  = IDLE;
                    end else begin
                        w_mem_we     = 1'b1;
                        w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
                        if (w_is_end) begin
                            w_commit_nxt = r_wr_ptr + PTR_ONE;
                            w_state_nxt  = IDLE;
                        end
                    end
                end
            end
            DISCARD: begin
                if (bus.writeEnable && w_is_end) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_commit_ptr <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_commit_ptr <= w_commit_nxt;
        end
    end

    assign w_base_nxt   = w_commit_nxt;
    assign bus.pktState = r_state;
`else
    logic w_wr_acc;

    assign w_wr_acc     = bus.writeEnable && !r_full;
    assign w_mem_we     = w_wr_acc;
    assign w_wr_ptr_nxt = r_wr_ptr + PW'(w_wr_acc);
    assign w_base_nxt   = w_wr_ptr_nxt;
    assign w_full_out   = r_full;
    assign w_ovf_set    = bus.writeEnable && r_full;
    assign bus.pktState = IDLE;
`endif

    assign w_level_nxt = w_base_nxt - w_rd_ptr_nxt;
    assign w_full_nxt  = (w_wr_ptr_nxt[DEPTH_LOG2] != w_rd_ptr_nxt[DEPTH_LOG2]) &&
                         (w_wr_ptr_nxt[DEPTH_LOG2-1:0] == w_rd_ptr_nxt[DEPTH_LOG2-1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_level  <= w_level_nxt;
            r_full   <= w_full_nxt;
            r_empty  <= (w_level_nxt == '0);
            // A new error event wins over a simultaneous clear.
            if (w_ovf_set)            r_overflow <= 1'b1;
            else if (bus.clearStatus) r_overflow <= 1'b0;
            if (w_udf_set)            r_underflow <= 1'b1;
            else if (bus.clearStatus) r_underflow <= 1'b0;
        end
    end

    spw_fifo_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_mem_we),
        .i_waddr (r_wr_ptr[DEPTH_LOG2-1:0]),
        .i_wdata (bus.dataIn),
        .i_re    (w_rd_acc),
        .i_raddr (r_rd_ptr[DEPTH_LOG2-1:0]),
        .o_rdata (bus.dataOut)
    );

    assign bus.full      = w_full_out;
    assign bus.empty     = r_empty;
    assign bus.level     = r_level;
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;

endmodule
